// File: rtl/dma_cmd_queue.sv
// rtl/dma_cmd_queue.sv - CPU register bank, descriptor FIFO and dispatcher feeding a DMA engine.
// Descriptors are staged via registers, queued on PUSH and issued one at a time with a START pulse.
module dma_cmd_queue #(
    parameter int QDEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [3:0]  reg_i,
    input  logic [7:0]  din_i,
    output logic [7:0]  dout_o,
    output logic        irq_o,
    output logic [15:0] src_addr_o,
    output logic [15:0] dst_addr_o,
    output logic [7:0]  len_o,
    output logic [7:0]  inc_o,
    output logic        start_o,
    input  logic        dma_done_i,
    input  logic        dma_fail_i,
    input  logic        dma_err_i
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_START = 2'd1;
    localparam logic [1:0] D_BUSY  = 2'd2;
    localparam logic [1:0] D_HALT  = 2'd3;

    logic [15:0]   src_q, dst_q;
    logic [7:0]    len_q, inc_q;
    logic [3:0]    ctrl_q;
    logic          done_f_q, fail_f_q, err_f_q, ovf_q;
    logic          done_f_d, fail_f_d, err_f_d, ovf_d;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   src_addr_q, dst_addr_q;
    logic [7:0]    len_out_q, inc_out_q;
    logic [7:0]    dout_q, rdata;
    logic [47:0]   mem_q [QDEPTH];
    logic [47:0]   head;

    logic wr_en, rd_en, ctrl_wr, flush, push_req, push_ok, ovf_set, pop;
    logic fifo_empty, fifo_full, busy;
    logic [7:0] stat_clr;

    assign wr_en      = cs_i & wr_i;
    assign rd_en      = cs_i & rd_i;
    assign ctrl_wr    = wr_en && (reg_i == 4'd6);
    assign flush      = ctrl_wr & din_i[1];
    assign push_req   = ctrl_wr & din_i[0] & ~din_i[1];
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(QDEPTH));
    assign pop        = (state_q == D_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign head       = mem_q[rptr_q];
    assign busy       = (state_q != D_IDLE) || !fifo_empty;
    assign stat_clr   = (wr_en && (reg_i == 4'd7)) ? din_i : 8'h00;

    assign done_f_d = dma_done_i | (done_f_q & ~stat_clr[1]);
    assign fail_f_d = dma_fail_i | (fail_f_q & ~stat_clr[2]);
    assign err_f_d  = dma_err_i  | (err_f_q  & ~stat_clr[3]);
    assign ovf_d    = ovf_set    | (ovf_q    & ~stat_clr[6]);

    always_comb begin
        cnt_d = cnt_q;
        if (flush)
            cnt_d = '0;
        else if (push_ok && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop)
            cnt_d = cnt_q - CW'(1);
    end

    // HALT releases as soon as FAIL_F is being cleared, saving a cycle on resume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE:  if (pop) state_d = D_START;
            D_START: state_d = D_BUSY;
            D_BUSY: begin
                if (dma_done_i)
                    state_d = D_IDLE;
                else if (dma_fail_i)
                    state_d = ctrl_q[3] ? D_HALT : D_IDLE;
            end
            D_HALT:  if (!fail_f_d) state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    always_comb begin
        rdata = 8'h00;
        case (reg_i)
            4'd0: rdata = src_q[7:0];
            4'd1: rdata = src_q[15:8];
            4'd2: rdata = dst_q[7:0];
            4'd3: rdata = dst_q[15:8];
            4'd4: rdata = len_q;
            4'd5: rdata = inc_q;
            4'd6: rdata = {2'b00, ctrl_q, 2'b00};
            4'd7: rdata = {1'b0, ovf_q, fifo_empty, fifo_full, err_f_q, fail_f_q, done_f_q, busy};
            4'd8: rdata = 8'(cnt_q);
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wptr_q] <= {src_q, dst_q, len_q, inc_q};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            inc_q      <= '0;
            ctrl_q     <= '0;
            done_f_q   <= 1'b0;
            fail_f_q   <= 1'b0;
            err_f_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            state_q    <= D_IDLE;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            len_out_q  <= '0;
            inc_out_q  <= '0;
            dout_q     <= '0;
        end else begin
            if (wr_en) begin
                case (reg_i)
                    4'd0: src_q[7:0]  <= din_i;
                    4'd1: src_q[15:8] <= din_i;
                    4'd2: dst_q[7:0]  <= din_i;
                    4'd3: dst_q[15:8] <= din_i;
                    4'd4: len_q       <= din_i;
                    4'd5: inc_q       <= din_i;
                    4'd6: ctrl_q      <= din_i[5:2];
                    default: ;
                endcase
            end
            done_f_q <= done_f_d;
            fail_f_q <= fail_f_d;
            err_f_q  <= err_f_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push_ok) wptr_q <= wptr_q + AW'(1);
                if (pop)     rptr_q <= rptr_q + AW'(1);
            end
            if (pop) begin
                src_addr_q <= head[47:32];
                dst_addr_q <= head[31:16];
                len_out_q  <= head[15:8];
                inc_out_q  <= head[7:0];
            end
            if (rd_en)
                dout_q <= rdata;
        end
    end

    assign dout_o     = dout_q;
    assign src_addr_o = src_addr_q;
    assign dst_addr_o = dst_addr_q;
    assign len_o      = len_out_q;
    assign inc_o      = inc_out_q;
    assign start_o    = (state_q == D_START);
    assign irq_o      = |({err_f_q, fail_f_q, done_f_q} & ctrl_q[2:0]);

endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb/tb_dma_cmd_queue.sv - directed self-checking bench for dma_cmd_queue.
module tb_dma_cmd_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  regsel = 4'd0;
    logic [7:0]  din = 8'd0;
    logic [7:0]  dout;
    logic        irq;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  len, inc;
    logic        start;
    logic        dma_done = 1'b0, dma_fail = 1'b0, dma_err = 1'b0;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    dma_cmd_queue #(.QDEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .cs_i(cs), .rd_i(rd), .wr_i(wr), .reg_i(regsel), .din_i(din),
        .dout_o(dout), .irq_o(irq), .src_addr_o(src_addr), .dst_addr_o(dst_addr), .len_o(len),
        .inc_o(inc), .start_o(start), .dma_done_i(dma_done), .dma_fail_i(dma_fail), .dma_err_i(dma_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start) start_cnt <= start_cnt + 1;

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; regsel = a; din = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; regsel = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = dout;
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) dma_done = 1'b1;
        if (which == 1) dma_fail = 1'b1;
        if (which == 2) dma_err = 1'b1;
        @(negedge clk);
        dma_done = 1'b0; dma_fail = 1'b0; dma_err = 1'b0;
    endtask

    task automatic wait_start(input int max, output logic found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (start) found = 1'b1;
        end
    endtask

    task automatic push_src(input logic [7:0] lo, input logic [7:0] ctrl);
        wr_reg(4'd0, lo);
        wr_reg(4'd6, ctrl);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        checks++; if (start !== 1'b0 || irq !== 1'b0 || src_addr !== 16'h0 || dout !== 8'h00) begin
            errors++; $display("FAIL reset_outputs start=%b irq=%b src=%h dout=%h expected 0", start, irq, src_addr, dout);
        end
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL reset_status got %h expected 20", d); end
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_qcount got %h expected 00", d); end
    endtask

    task automatic test_single;
        logic [7:0] d;
        wr_reg(4'd0, 8'h00); wr_reg(4'd1, 8'h10);
        wr_reg(4'd2, 8'h00); wr_reg(4'd3, 8'h20);
        wr_reg(4'd4, 8'h04); wr_reg(4'd5, 8'h01);
        wr_reg(4'd6, 8'h05);
        @(negedge clk);
        checks++; if (start !== 1'b1 || src_addr !== 16'h1000 || dst_addr !== 16'h2000 || len !== 8'h04 || inc !== 8'h01) begin
            errors++; $display("FAIL single_start start=%b src=%h dst=%h len=%h inc=%h expected 1 1000 2000 04 01", start, src_addr, dst_addr, len, inc);
        end
        @(negedge clk);
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_one_cycle got %b expected 0", start); end
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h21) begin errors++; $display("FAIL single_busy_status got %h expected 21", d); end
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL single_qcount got %h expected 00", d); end
        rd_reg(4'd6, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL ctrl_readback got %h expected 04", d); end
        rd_reg(4'd10, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h expected 00", d); end
        pulse(0);
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h22 || irq !== 1'b1) begin
            errors++; $display("FAIL single_done status=%h irq=%b expected 22 1", d, irq);
        end
        wr_reg(4'd7, 8'h02);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b expected 0", irq); end
    endtask

    task automatic test_fifo_full;
        logic [7:0] d;
        logic found;
        int s0;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) push_src(8'h10 + 8'(i), 8'h05);
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL full_status got %h expected 11", d); end
        push_src(8'h15, 8'h05);
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h51) begin errors++; $display("FAIL ovf_status got %h expected 51", d); end
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL full_qcount got %h expected 04", d); end
        checks++; if (src_addr !== 16'h1010) begin errors++; $display("FAIL fifo_first got %h expected 1010", src_addr); end
        for (int i = 1; i < 5; i++) begin
            pulse(0);
            wait_start(5, found);
            checks++; if (!found || src_addr !== 16'h1010 + 16'(i)) begin
                errors++; $display("FAIL fifo_order_%0d found=%b src=%h expected %h", i, found, src_addr, 16'h1010 + 16'(i));
            end
        end
        pulse(0);
        repeat (3) @(negedge clk);
        checks++; if (start_cnt - s0 !== 5) begin errors++; $display("FAIL start_total got %0d expected 5", start_cnt - s0); end
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h62) begin errors++; $display("FAIL drained_status got %h expected 62", d); end
        wr_reg(4'd7, 8'h4E);
    endtask

    task automatic test_halt;
        logic [7:0] d;
        logic found;
        int s0;
        for (int i = 0; i < 3; i++) push_src(8'h30 + 8'(i), 8'h25);
        s0 = start_cnt;
        pulse(1);
        repeat (4) @(negedge clk);
        checks++; if (start_cnt !== s0) begin errors++; $display("FAIL halt_no_start got %0d starts expected 0", start_cnt - s0); end
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL halt_status got %h expected 05", d); end
        wr_reg(4'd7, 8'h04);
        wait_start(2, found);
        checks++; if (!found || src_addr !== 16'h1031) begin
            errors++; $display("FAIL halt_resume found=%b src=%h expected 1 1031", found, src_addr);
        end
        wr_reg(4'd6, 8'h04);
        pulse(1);
        wait_start(3, found);
        checks++; if (!found || src_addr !== 16'h1032) begin
            errors++; $display("FAIL nohalt_next found=%b src=%h expected 1 1032", found, src_addr);
        end
        pulse(0);
        wr_reg(4'd7, 8'h4E);
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL halt_cleanup got %h expected 20", d); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        int s0;
        for (int i = 0; i < 3; i++) push_src(8'h40 + 8'(i), 8'h05);
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL b2b_pre_qcount got %h expected 02", d); end
        @(negedge clk);
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        cs = 1'b1; wr = 1'b1; regsel = 4'd6; din = 8'h05;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL pushpop_qcount got %h expected 02", d); end
        wr_reg(4'd7, 8'h4E);
        wr_reg(4'd6, 8'h07);
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL flush_qcount got %h expected 00", d); end
        s0 = start_cnt;
        pulse(0);
        repeat (4) @(negedge clk);
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h22 || start_cnt !== s0) begin
            errors++; $display("FAIL flush_inflight status=%h starts=%0d expected 22 0", d, start_cnt - s0);
        end
        wr_reg(4'd7, 8'h4E);
    endtask

    task automatic test_reset_midflight;
        logic [7:0] d;
        int s0;
        for (int i = 0; i < 4; i++) push_src(8'h50 + 8'(i), 8'h05);
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL mid_qcount got %h expected 03", d); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (start !== 1'b0 || src_addr !== 16'h0) begin
            errors++; $display("FAIL mid_reset_out start=%b src=%h expected 0 0000", start, src_addr);
        end
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL mid_reset_status got %h expected 20", d); end
        rd_reg(4'd8, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_qcount got %h expected 00", d); end
        s0 = start_cnt;
        pulse(0);
        repeat (3) @(negedge clk);
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h22 || start_cnt !== s0) begin
            errors++; $display("FAIL late_done status=%h starts=%0d expected 22 0", d, start_cnt - s0);
        end
        wr_reg(4'd6, 8'h10);
        pulse(2);
        rd_reg(4'd7, d);
        checks++; if (d !== 8'h2A || irq !== 1'b1) begin
            errors++; $display("FAIL err_irq status=%h irq=%b expected 2a 1", d, irq);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_halt();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
